jk_cmd_sequencer: RTL and testbench

//  Upstream driver for the async-reset JK flip-flop stage. Accepts queued commands
//  (HOLD/RESET/SET/TOGGLE + repeat length) over a valid/ready handshake, buffers

---
 rtl/jk_seq_pkg.sv | 24 ++
 rtl/jk_seq_fifo.sv | 42 ++++
 rtl/jk_cmd_sequencer.sv | 119 +++++++++++
 tb/tb_jk_cmd_sequencer.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/jk_seq_pkg.sv
// Shared types for the JK command sequencer: opcodes, FSM states and the queued command.
package jk_seq_pkg;

    // Widest run-length field a queued command can carry; the top zero-extends into it.
    localparam int CMD_LEN_W = 8;

    typedef enum logic [1:0] {
        OP_HOLD   = 2'b00,
        OP_RESET  = 2'b01,
        OP_SET    = 2'b10,
        OP_TOGGLE = 2'b11
    } op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef struct packed {
        op_t                  op;
        logic [CMD_LEN_W-1:0] len;
    } cmd_t;

endpackage

// File: rtl/jk_seq_fifo.sv
// DEPTH-entry synchronous command FIFO with async active-low reset and full/empty flags.
module jk_seq_fifo
    import jk_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic pop,
    input  cmd_t din,
    output cmd_t dout,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    cmd_t        mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/jk_cmd_sequencer.sv
// Queues HOLD/RESET/SET/TOGGLE commands and replays each as registered J/K levels for len clocks.
// Define JK_SEQ_CHECK_EN to add the q_fb/mismatch ports and the flip-flop Q model.
module jk_cmd_sequencer
    import jk_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             asyncReset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_len,
    output logic             J,
    output logic             K,
    output logic             busy,
    output logic             done
`ifdef JK_SEQ_CHECK_EN
    ,
    input  logic             q_fb,
    output logic             mismatch
`endif
);

    state_t           state;
    logic [CNT_W-1:0] rem;
    cmd_t             push_cmd;
    cmd_t             head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             head_live;
    logic             last_cycle;

    assign push_cmd.op  = op_t'(cmd_op);
    assign push_cmd.len = (CMD_LEN_W)'(cmd_len);

    assign cmd_ready  = !fifo_full;
    assign push       = cmd_valid && !fifo_full;
    // rem==0 in RUN only while skipping zero-length heads.
    assign last_cycle = (state == ST_IDLE) || (rem <= 1);
    assign pop        = !fifo_empty && last_cycle;
    assign head_live  = (head.len != '0);
    assign busy       = (state == ST_RUN) || !fifo_empty;

    jk_seq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (asyncReset_n),
        .push  (push),
        .pop   (pop),
        .din   (push_cmd),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge asyncReset_n) begin
        if (!asyncReset_n) begin
            state <= ST_IDLE;
            rem   <= '0;
            J     <= 1'b0;
            K     <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty && head_live) begin
                        state  <= ST_RUN;
                        {J, K} <= head.op;
                        rem    <= head.len[CNT_W-1:0];
                    end
                end
                ST_RUN: begin
                    if (rem > 1) begin
                        rem <= rem - 1'b1;
                    end else if (!fifo_empty) begin
                        if (head_live) begin
                            {J, K} <= head.op;
                            rem    <= head.len[CNT_W-1:0];
                        end else begin
                            {J, K} <= 2'b00;
                            rem    <= '0;
                        end
                    end else begin
                        {J, K} <= 2'b00;
                        rem    <= '0;
                        state  <= ST_IDLE;
                        done   <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef JK_SEQ_CHECK_EN
    logic exp_q;

    // Mirrors the JK stage: both sides see the same J/K at the same edge.
    always_ff @(posedge clk or negedge asyncReset_n) begin
        if (!asyncReset_n) begin
            exp_q    <= 1'b0;
            mismatch <= 1'b0;
        end else begin
            case ({J, K})
                2'b01:   exp_q <= 1'b0;
                2'b10:   exp_q <= 1'b1;
                2'b11:   exp_q <= ~exp_q;
                default: exp_q <= exp_q;
            endcase
            if (q_fb != exp_q) mismatch <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Directed bench for jk_cmd_sequencer; checker scenario runs only when JK_SEQ_CHECK_EN is defined.
module tb_jk_cmd_sequencer;
    import jk_seq_pkg::*;

    logic       clk = 1'b0;
    logic       asyncReset_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_len;
    logic       J, K, busy, done;
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [19:0] hist;

`ifdef JK_SEQ_CHECK_EN
    logic q_fb, mismatch, q_model, force_zero;
    always @(posedge clk or negedge asyncReset_n) begin
        if (!asyncReset_n) q_model <= 1'b0;
        else case ({J, K})
            2'b01:   q_model <= 1'b0;
            2'b10:   q_model <= 1'b1;
            2'b11:   q_model <= ~q_model;
            default: q_model <= q_model;
        endcase
    end
    assign q_fb = force_zero ? 1'b0 : q_model;
`endif

    always #5 clk = ~clk;

    jk_cmd_sequencer dut (
        .clk          (clk),
        .asyncReset_n (asyncReset_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_len      (cmd_len),
        .J            (J),
        .K            (K),
        .busy         (busy),
        .done         (done)
`ifdef JK_SEQ_CHECK_EN
        ,
        .q_fb         (q_fb),
        .mismatch     (mismatch)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [3:0] len);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = len;
    endtask

    initial begin
        asyncReset_n = 1'b0;
        cmd_valid    = 1'b0;
        cmd_op       = 2'b00;
        cmd_len      = 4'd0;
`ifdef JK_SEQ_CHECK_EN
        force_zero   = 1'b0;
`endif
        #1;
        chk("rst_jk", {30'd0, J, K}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
        #11 asyncReset_n = 1'b1;

        // 1: SET len=3 from idle
        drive(OP_SET, 4'd3);
        tick(); cmd_valid = 1'b0;
        tick(); chk("t1_e1_jk", {30'd0, J, K}, 32'b10); chk("t1_e1_busy", {31'd0, busy}, 32'd1);
        tick(); chk("t1_e2_jk", {30'd0, J, K}, 32'b10);
        tick(); chk("t1_e3_jk", {30'd0, J, K}, 32'b10); chk("t1_e3_done", {31'd0, done}, 32'd0);
        tick(); chk("t1_e4_jk", {30'd0, J, K}, 32'b00); chk("t1_e4_done", {31'd0, done}, 32'd1);
        tick(); chk("t1_e5_done", {31'd0, done}, 32'd0); chk("t1_e5_busy", {31'd0, busy}, 32'd0);

        // 2: SET2 then TOGGLE3 back-to-back
        drive(OP_SET, 4'd2);
        tick(); drive(OP_TOGGLE, 4'd3);
        tick(); cmd_valid = 1'b0;
        chk("t2_e1_jk", {30'd0, J, K}, 32'b10);
        tick(); chk("t2_e2_jk", {30'd0, J, K}, 32'b10); chk("t2_e2_done", {31'd0, done}, 32'd0);
        tick(); chk("t2_e3_jk", {30'd0, J, K}, 32'b11); chk("t2_e3_done", {31'd0, done}, 32'd0);
        tick(); chk("t2_e4_jk", {30'd0, J, K}, 32'b11);
        tick(); chk("t2_e5_jk", {30'd0, J, K}, 32'b11); chk("t2_e5_done", {31'd0, done}, 32'd0);
        tick(); chk("t2_e6_jk", {30'd0, J, K}, 32'b00); chk("t2_e6_done", {31'd0, done}, 32'd1);
        tick(); chk("t2_e7_done", {31'd0, done}, 32'd0);

        // idle zero-length command is discarded silently
        drive(OP_SET, 4'd0);
        tick(); cmd_valid = 1'b0;
        tick(); chk("z_e1_jk", {30'd0, J, K}, 32'b00); chk("z_e1_busy", {31'd0, busy}, 32'd0);
        chk("z_e1_done", {31'd0, done}, 32'd0);
        tick(); chk("z_e2_done", {31'd0, done}, 32'd0);

        // 4: SET2, zero-length, RESET1
        drive(OP_SET, 4'd2);
        tick(); drive(OP_TOGGLE, 4'd0);
        tick(); chk("t4_e1_jk", {30'd0, J, K}, 32'b10); drive(OP_RESET, 4'd1);
        tick(); chk("t4_e2_jk", {30'd0, J, K}, 32'b10); cmd_valid = 1'b0;
        tick(); chk("t4_e3_jk", {30'd0, J, K}, 32'b00); chk("t4_e3_done", {31'd0, done}, 32'd0);
        tick(); chk("t4_e4_jk", {30'd0, J, K}, 32'b01); chk("t4_e4_done", {31'd0, done}, 32'd0);
        tick(); chk("t4_e5_jk", {30'd0, J, K}, 32'b00); chk("t4_e5_done", {31'd0, done}, 32'd1);
        tick(); chk("t4_e6_done", {31'd0, done}, 32'd0); chk("t4_e6_busy", {31'd0, busy}, 32'd0);

        // 3: cmd_valid held with len=15; ready history before edges 0..19
        drive(OP_TOGGLE, 4'd15);
        for (int i = 0; i < 20; i++) begin
            hist[i] = cmd_ready;
            tick();
        end
        cmd_valid = 1'b0;
        chk("t3_ready_hist", {12'd0, hist}, 32'h2001F);
        chk("t3_jk", {30'd0, J, K}, 32'b11);
        chk("t3_busy", {31'd0, busy}, 32'd1);

        // 5: async reset mid TOGGLE run
        #2 asyncReset_n = 1'b0;
        #1;
        chk("t5_jk", {30'd0, J, K}, 32'b00);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_ready", {31'd0, cmd_ready}, 32'd1);
        tick();
        asyncReset_n = 1'b1;
        tick(); chk("t5_post_jk", {30'd0, J, K}, 32'b00); chk("t5_post_done", {31'd0, done}, 32'd0);
        tick(); chk("t5_post2_busy", {31'd0, busy}, 32'd0); chk("t5_post2_done", {31'd0, done}, 32'd0);

`ifdef JK_SEQ_CHECK_EN
        // 6: Q model tracking, then forced divergence
        drive(OP_SET, 4'd1);
        tick(); drive(OP_TOGGLE, 4'd2);
        tick(); cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("t6_clean", {31'd0, mismatch}, 32'd0);
        force_zero = 1'b1;
        tick(); chk("t6_flag", {31'd0, mismatch}, 32'd1);
        force_zero = 1'b0;
        tick(); tick(); chk("t6_sticky", {31'd0, mismatch}, 32'd1);
        #2 asyncReset_n = 1'b0;
        #1 chk("t6_rst", {31'd0, mismatch}, 32'd0);
        tick();
        asyncReset_n = 1'b1;
        tick(); chk("t6_after_rst", {31'd0, mismatch}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
